// File: rtl/tinytpu_result_tx.sv
// Bit-serial transmitter for the N x N result matrix: words in order, MSB first, tx_hold stalls.
// Optional per-word even parity bit when TINYTPU_TX_PARITY_EN is defined.
module tinytpu_result_tx #(
  parameter int D_W   = 8,
  parameter int N     = 2,
  parameter int RES_W = 2 * D_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [N*N*RES_W-1:0]   res_in,
  input  logic                   tx_hold,
  output logic                   data_out_z,
  output logic                   tx_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int NW  = N * N;
  localparam int WCW = (NW > 1) ? $clog2(NW) : 1;
  localparam int BCW = (RES_W > 1) ? $clog2(RES_W) : 1;
  localparam logic [BCW-1:0] BIT_TOP  = BCW'(RES_W - 1);
  localparam logic [WCW-1:0] WORD_TOP = WCW'(NW - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t               state, state_nx;
  logic [BCW-1:0]       bit_cnt, bit_nx;
  logic [WCW-1:0]       word_cnt, word_nx;
  logic                 dout_nx, rdy_nx, busy_nx, done_nx;
  logic                 word_end;
  logic [RES_W-1:0]     frame [NW];

`ifdef TINYTPU_TX_PARITY_EN
  logic                 par_phase, par_nx;
  assign word_end = par_phase;
`else
  assign word_end = (bit_cnt == '0);
`endif

  // Frame buffer only loads on acceptance, so res_in changes mid-frame are invisible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NW; k++) frame[k] <= '0;
    end else if (state == IDLE && load) begin
      for (int k = 0; k < NW; k++) frame[k] <= res_in[k*RES_W +: RES_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      data_out_z <= 1'b0;
      tx_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef TINYTPU_TX_PARITY_EN
      par_phase  <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_nx;
      word_cnt   <= word_nx;
      data_out_z <= dout_nx;
      tx_ready   <= rdy_nx;
      busy       <= busy_nx;
      done       <= done_nx;
`ifdef TINYTPU_TX_PARITY_EN
      par_phase  <= par_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    bit_nx   = bit_cnt;
    word_nx  = word_cnt;
    dout_nx  = data_out_z;
    rdy_nx   = 1'b0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
`ifdef TINYTPU_TX_PARITY_EN
    par_nx   = par_phase;
`endif
    case (state)
      IDLE: begin
        dout_nx = 1'b0;
        if (load) begin
          state_nx = SHIFT;
          bit_nx   = BIT_TOP;
          word_nx  = '0;
          dout_nx  = res_in[RES_W-1];
          rdy_nx   = 1'b1;
          busy_nx  = 1'b1;
`ifdef TINYTPU_TX_PARITY_EN
          par_nx   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        rdy_nx  = 1'b1;
        busy_nx = 1'b1;
        if (!tx_hold) begin
          if (word_end) begin
            if (word_cnt == WORD_TOP) begin
              state_nx = FIN;
              rdy_nx   = 1'b0;
              done_nx  = 1'b1;
              dout_nx  = 1'b0;
              bit_nx   = '0;
              word_nx  = '0;
            end else begin
              word_nx = word_cnt + 1'b1;
              bit_nx  = BIT_TOP;
              dout_nx = frame[word_cnt + 1'b1][RES_W-1];
            end
`ifdef TINYTPU_TX_PARITY_EN
            par_nx = 1'b0;
          end else if (bit_cnt == '0) begin
            // Even parity: the extra bit makes the word plus parity have an even count of ones.
            par_nx  = 1'b1;
            dout_nx = ^frame[word_cnt];
`endif
          end else begin
            bit_nx  = bit_cnt - 1'b1;
            dout_nx = frame[word_cnt][bit_cnt - 1'b1];
          end
        end
      end
      FIN: begin
        state_nx = IDLE;
        dout_nx  = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        dout_nx  = 1'b0;
      end
    endcase
  end

endmodule
